// File: rtl/cam_pixel_capture_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cam_cap_pkg: shared FSM states, decimation codes and FIFO entry layout. Rev 1.0
// ----------------------------------------------------------------------------
package cam_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_t;

    localparam logic [1:0] DECIM_1 = 2'd0;
    localparam logic [1:0] DECIM_2 = 2'd1;
    localparam logic [1:0] DECIM_4 = 2'd2;

    // Code 3 shares the /4 shift with code 2.
    function automatic logic [1:0] decim_shift(input logic [1:0] code);
        case (code)
            DECIM_1: decim_shift = 2'd0;
            DECIM_2: decim_shift = 2'd1;
            default: decim_shift = 2'd2;
        endcase
    endfunction

    // FIFO entry = {sof, eol, y, x, data}, data in the low bits.
    function automatic int ent_x_lsb(input int pix_w);
        return pix_w;
    endfunction

    function automatic int ent_y_lsb(input int pix_w, input int x_w);
        return pix_w + x_w;
    endfunction

    function automatic int ent_eol_bit(input int pix_w, input int x_w, input int y_w);
        return pix_w + x_w + y_w;
    endfunction

    function automatic int ent_width(input int pix_w, input int x_w, input int y_w);
        return pix_w + x_w + y_w + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_pixel_capture_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cam_pixel_capture_if: valid/ready pixel stream toward the framebuffer writer. Rev 1.0
// ----------------------------------------------------------------------------
interface cam_pixel_capture_if #(
    parameter int PIX_W = 16,
    parameter int X_W   = 10,
    parameter int Y_W   = 10
);
    logic             o_valid;
    logic             i_ready;
    logic [PIX_W-1:0] o_data;
    logic [X_W-1:0]   o_x;
    logic [Y_W-1:0]   o_y;
    logic             o_sof;
    logic             o_eol;

    modport master (output o_valid, o_data, o_x, o_y, o_sof, o_eol, input i_ready);
    modport slave  (input o_valid, o_data, o_x, o_y, o_sof, o_eol, output i_ready);
endinterface
`default_nettype wire

// File: rtl/cam_pixel_capture_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cam_cap_fifo: single-clock first-word-fall-through FIFO. Rev 1.0
// ----------------------------------------------------------------------------
module cam_cap_fifo #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4
) (
    input  wire logic              CLK,
    input  wire logic              RST_X,
    input  wire logic              wr_en,
    input  wire logic [DATA_W-1:0] wr_data,
    output logic                   full,
    input  wire logic              rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   empty
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [FIFO_AW:0]  wptr;
    logic [FIFO_AW:0]  rptr;
    logic              do_wr;
    logic              do_rd;

    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage is not reset; the read port is masked while empty instead.
    assign rd_data = empty ? '0 : mem[rptr[FIFO_AW-1:0]];

    always_ff @(posedge CLK) begin
        if (do_wr) mem[wptr[FIFO_AW-1:0]] <= wr_data;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cam_pixel_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cam_pixel_capture: oversampled parallel-camera capture with decimation and FIFO. Rev 1.0
// ----------------------------------------------------------------------------
module cam_pixel_capture
    import cam_cap_pkg::*;
#(
    parameter int PIX_W       = 16,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int FRAME_W     = 320,
    parameter int FRAME_H     = 240,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_AW     = 4
) (
    input  wire logic       CLK,
    input  wire logic       RST_X,
    input  wire logic       cam_pclk,
    input  wire logic       cam_vsync,
    input  wire logic       cam_href,
    input  wire logic [7:0] cam_din,
    input  wire logic       i_enable,
    input  wire logic       i_bpp2,
    input  wire logic [1:0] i_decim,
    cam_pixel_capture_if.master pix,
    output logic [7:0]      o_frame_cnt,
    output logic [15:0]     o_ovf_cnt,
    output logic            o_line_err
);
    localparam int SW      = 11;
    localparam int X_LSB   = ent_x_lsb(PIX_W);
    localparam int Y_LSB   = ent_y_lsb(PIX_W, X_W);
    localparam int EOL_BIT = ent_eol_bit(PIX_W, X_W, Y_W);
    localparam int SOF_BIT = EOL_BIT + 1;
    localparam int ENTRY_W = ent_width(PIX_W, X_W, Y_W);
    localparam logic [X_W-1:0] FW_X = X_W'(FRAME_W);
    localparam logic [Y_W-1:0] FH_Y = Y_W'(FRAME_H);

    logic [SW*SYNC_STAGES-1:0] sync_sr;
    logic [SW-1:0]             sync_out;
    logic                      s_pclk, s_vsync, s_href;
    logic [7:0]                s_din;
    logic                      pclk_prev, pclk_rise;
    logic                      href_q, vsync_q, href_fall, vsync_rise;

    cap_state_t state, state_nxt;
    logic       vs_seen, capturing, frame_start;
    logic       bpp2_l;
    logic [1:0] shift_l, dmask;
    logic       phase;
    logic [7:0] hi_byte;
    logic [X_W-1:0] x_raw, eol_x;
    logic [Y_W-1:0] y_raw;
    logic             pix_done, keep;
    logic [PIX_W-1:0] pix_val;
    logic             push;
    logic [ENTRY_W-1:0] entry_q, rd_data;
    logic             fifo_full, fifo_empty;

    assign sync_out = sync_sr[SW*SYNC_STAGES-1 -: SW];
    assign s_pclk   = sync_out[10];
    assign s_vsync  = sync_out[9];
    assign s_href   = sync_out[8];
    assign s_din    = sync_out[7:0];

    // Edges of href/vsync are only judged on PCLK rising samples.
    assign pclk_rise  = s_pclk && !pclk_prev;
    assign href_fall  = pclk_rise && href_q && !s_href;
    assign vsync_rise = pclk_rise && !vsync_q && s_vsync;

    assign capturing   = (state == ST_CAPTURE);
    assign frame_start = (state == ST_WAIT_VS) && (state_nxt == ST_CAPTURE);
    assign pix_done    = capturing && pclk_rise && s_href && !vsync_rise && (!bpp2_l || phase);
    assign pix_val     = bpp2_l ? PIX_W'({hi_byte, s_din}) : PIX_W'(s_din);

    always_comb begin
        case (shift_l)
            2'd0:    dmask = 2'b00;
            2'd1:    dmask = 2'b01;
            default: dmask = 2'b11;
        endcase
    end

    assign eol_x = FW_X - (X_W'(1) << shift_l);
    assign keep  = ((x_raw[1:0] & dmask) == 2'b00) && ((y_raw[1:0] & dmask) == 2'b00) &&
                   (x_raw < FW_X) && (y_raw < FH_Y);

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (i_enable) state_nxt = ST_WAIT_VS;
            ST_WAIT_VS: begin
                if (!i_enable)                            state_nxt = ST_IDLE;
                else if (vs_seen && pclk_rise && !s_vsync) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: if (vsync_rise) state_nxt = i_enable ? ST_WAIT_VS : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            sync_sr     <= '0;
            pclk_prev   <= 1'b0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            vs_seen     <= 1'b0;
            bpp2_l      <= 1'b0;
            shift_l     <= 2'd0;
            phase       <= 1'b0;
            hi_byte     <= 8'd0;
            x_raw       <= '0;
            y_raw       <= '0;
            push        <= 1'b0;
            entry_q     <= '0;
            o_frame_cnt <= 8'd0;
            o_ovf_cnt   <= 16'd0;
            o_line_err  <= 1'b0;
        end else begin
            sync_sr   <= {sync_sr[SW*(SYNC_STAGES-1)-1:0], cam_pclk, cam_vsync, cam_href, cam_din};
            pclk_prev <= s_pclk;
            if (pclk_rise) begin
                href_q  <= s_href;
                vsync_q <= s_vsync;
            end

            if (state != ST_WAIT_VS)        vs_seen <= 1'b0;
            else if (pclk_rise && s_vsync)  vs_seen <= 1'b1;

            o_line_err <= capturing && href_fall && (x_raw != FW_X);
            push       <= pix_done && keep;
            if (pix_done)
                entry_q <= {(x_raw == '0) && (y_raw == '0), x_raw == eol_x,
                            y_raw >> shift_l, x_raw >> shift_l, pix_val};

            if (capturing && vsync_rise) o_frame_cnt <= o_frame_cnt + 8'd1;
            // Full is judged before any same-cycle pop, so a stalled FIFO always drops.
            if (push && fifo_full && (o_ovf_cnt != 16'hFFFF)) o_ovf_cnt <= o_ovf_cnt + 16'd1;

            if (frame_start) begin
                x_raw   <= '0;
                y_raw   <= '0;
                phase   <= 1'b0;
                bpp2_l  <= i_bpp2;
                shift_l <= decim_shift(i_decim);
            end else if (capturing && vsync_rise) begin
                x_raw <= '0;
                phase <= 1'b0;
            end else if (capturing && pclk_rise) begin
                if (!s_href) begin
                    phase <= 1'b0;
                    if (href_fall) begin
                        x_raw <= '0;
                        if ((x_raw != '0) && (y_raw != '1)) y_raw <= y_raw + 1'b1;
                    end
                end else if (bpp2_l && !phase) begin
                    hi_byte <= s_din;
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (x_raw != '1) x_raw <= x_raw + 1'b1;
                end
            end
        end
    end

    cam_cap_fifo #(
        .DATA_W (ENTRY_W),
        .FIFO_AW(FIFO_AW)
    ) u_fifo (
        .CLK    (CLK),
        .RST_X  (RST_X),
        .wr_en  (push),
        .wr_data(entry_q),
        .full   (fifo_full),
        .rd_en  (pix.i_ready),
        .rd_data(rd_data),
        .empty  (fifo_empty)
    );

    assign pix.o_valid = !fifo_empty;
    assign pix.o_data  = rd_data[PIX_W-1:0];
    assign pix.o_x     = rd_data[X_LSB +: X_W];
    assign pix.o_y     = rd_data[Y_LSB +: Y_W];
    assign pix.o_eol   = rd_data[EOL_BIT];
    assign pix.o_sof   = rd_data[SOF_BIT];
endmodule
`default_nettype wire

// File: tb/tb_cam_pixel_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cam_pixel_capture: directed bench on a reduced 32x8 frame, FIFO depth 16. Rev 1.0
// ----------------------------------------------------------------------------
module tb_cam_pixel_capture;
    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic        cam_pclk = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0;
    logic [7:0]  cam_din = 8'h00;
    logic        enable = 1'b0, bpp2 = 1'b1;
    logic [1:0]  decim = 2'd0;
    logic [7:0]  frame_cnt;
    logic [15:0] ovf_cnt;
    logic        line_err;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] d;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        sof;
        logic        eol;
    } pix_t;
    pix_t q[$];
    int   lerr_cnt = 0;

    cam_pixel_capture_if #(.PIX_W(16), .X_W(10), .Y_W(10)) px ();

    cam_pixel_capture #(
        .PIX_W(16), .X_W(10), .Y_W(10), .FRAME_W(32), .FRAME_H(8),
        .SYNC_STAGES(2), .FIFO_AW(4)
    ) dut (
        .CLK(clk), .RST_X(rst_x),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_din(cam_din),
        .i_enable(enable), .i_bpp2(bpp2), .i_decim(decim),
        .pix(px),
        .o_frame_cnt(frame_cnt), .o_ovf_cnt(ovf_cnt), .o_line_err(line_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (px.o_valid && px.i_ready)
            q.push_back('{d: px.o_data, x: px.o_x, y: px.o_y, sof: px.o_sof, eol: px.o_eol});
        if (line_err) lerr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pbyte(input logic vs, input logic hs, input logic [7:0] d);
        cam_pclk = 1'b0; cam_vsync = vs; cam_href = hs; cam_din = d;
        clk_wait(2);
        cam_pclk = 1'b1;
        clk_wait(2);
    endtask

    task automatic send_pixels(input int x0, input int n, input int y, input bit two);
        for (int i = x0; i < x0 + n; i++) begin
            if (two) begin
                pbyte(1'b0, 1'b1, 8'hA5 ^ i[7:0]);
                pbyte(1'b0, 1'b1, 8'h3C ^ y[7:0]);
            end else begin
                pbyte(1'b0, 1'b1, 8'h7E ^ i[7:0]);
            end
        end
    endtask

    task automatic gap(input int n);
        repeat (n) pbyte(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vs_high(input int n);
        repeat (n) pbyte(1'b1, 1'b0, 8'h00);
    endtask

    task automatic lines(input int y0, input int n, input bit two);
        for (int y = y0; y < y0 + n; y++) begin
            send_pixels(0, 32, y, two);
            gap(2);
        end
    endtask

    initial begin
        int b;
        int lb;
        px.i_ready = 1'b1;

        // Reset state
        clk_wait(3);
        check("rst_valid", px.o_valid, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_ovf", ovf_cnt, 0);
        check("rst_line_err", line_err, 0);
        rst_x = 1'b1;
        clk_wait(2);

        // 1: bpp2, /1, full frame, plus first-pixel latency
        enable = 1'b1; bpp2 = 1'b1; decim = 2'd0;
        clk_wait(2);
        b = q.size(); lb = lerr_cnt;
        vs_high(3); gap(2);
        cam_href = 1'b1; cam_din = 8'hA5; cam_pclk = 1'b0; clk_wait(2);
        cam_pclk = 1'b1; clk_wait(2);
        cam_pclk = 1'b0; cam_din = 8'h3C; clk_wait(2);
        cam_pclk = 1'b1; clk_wait(3);
        check("t1_lat_early", px.o_valid, 0);
        clk_wait(1);
        check("t1_lat_valid", px.o_valid, 1);
        send_pixels(1, 31, 0, 1'b1); gap(2);
        lines(1, 7, 1'b1);
        bpp2 = 1'b0; decim = 2'd1;
        vs_high(3);
        check("t1_count", q.size() - b, 256);
        check("t1_first_data", q[b].d, 16'hA53C);
        check("t1_first_xy", {q[b].x, q[b].y}, 20'h0);
        check("t1_first_sof", q[b].sof, 1);
        check("t1_eol_row0", {q[b+31].eol, q[b+31].x}, {1'b1, 10'd31});
        check("t1_last_xy", {q[b+255].x, q[b+255].y}, {10'd31, 10'd7});
        check("t1_last_eol", q[b+255].eol, 1);
        check("t1_last_data", q[b+255].d, 16'hBA3B);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_line_err", lerr_cnt - lb, 0);

        // 2: bpp1, /2
        b = q.size();
        gap(2);
        lines(0, 8, 1'b0);
        bpp2 = 1'b1; decim = 2'd0;
        vs_high(3);
        check("t2_count", q.size() - b, 64);
        check("t2_first_data", q[b].d, 16'h007E);
        check("t2_first_sof", q[b].sof, 1);
        check("t2_second", {q[b+1].x, q[b+1].d}, {10'd1, 16'h007C});
        check("t2_no_eol_x14", q[b+14].eol, 0);
        check("t2_eol_x15", {q[b+15].eol, q[b+15].x, q[b+15].y}, {1'b1, 10'd15, 10'd0});
        check("t2_row1_start", {q[b+16].x, q[b+16].y, q[b+16].sof}, {10'd0, 10'd1, 1'b0});
        check("t2_last_xy", {q[b+63].x, q[b+63].y}, {10'd15, 10'd3});
        check("t2_frame_cnt", frame_cnt, 2);

        // 3: stall a full line into a 16-deep FIFO
        gap(2);
        b = q.size();
        px.i_ready = 1'b0;
        send_pixels(0, 32, 0, 1'b1); gap(2);
        check("t3_stall_valid", px.o_valid, 1);
        check("t3_stall_head", {px.o_data, px.o_x, px.o_y, px.o_sof}, {16'hA53C, 10'd0, 10'd0, 1'b1});
        clk_wait(20);
        check("t3_hold_valid", px.o_valid, 1);
        check("t3_hold_head", {px.o_data, px.o_x, px.o_y, px.o_sof}, {16'hA53C, 10'd0, 10'd0, 1'b1});
        check("t3_ovf", ovf_cnt, 16);
        check("t3_no_pop", q.size() - b, 0);
        px.i_ready = 1'b1;
        clk_wait(24);
        check("t3_drained", q.size() - b, 16);
        for (int i = 0; i < 16; i++) check("t3_order_x", q[b+i].x, i);
        check("t3_empty", px.o_valid, 0);
        lines(1, 7, 1'b1);
        vs_high(3);
        check("t3_frame_cnt", frame_cnt, 3);
        check("t3_ovf_final", ovf_cnt, 16);

        // 4: short line, then vsync abort mid-line
        gap(2);
        b = q.size(); lb = lerr_cnt;
        send_pixels(0, 30, 0, 1'b1); gap(2);
        check("t4_short_err", lerr_cnt - lb, 1);
        send_pixels(0, 32, 1, 1'b1); gap(2);
        check("t4_full_no_err", lerr_cnt - lb, 1);
        send_pixels(0, 10, 2, 1'b1);
        pbyte(1'b0, 1'b1, 8'h55);
        pbyte(1'b1, 1'b1, 8'hFF);
        vs_high(3);
        check("t4_abort_no_err", lerr_cnt - lb, 1);
        check("t4_count", q.size() - b, 72);
        check("t4_last_xy", {q[q.size()-1].x, q[q.size()-1].y}, {10'd9, 10'd2});
        check("t4_frame_cnt", frame_cnt, 4);

        // 5: mode change mid-frame, then enable drop mid-frame
        gap(2);
        b = q.size();
        send_pixels(0, 32, 0, 1'b1); gap(2);
        bpp2 = 1'b0; decim = 2'd2;
        send_pixels(0, 32, 1, 1'b1); gap(2);
        check("t4_next_sof", {q[b].sof, q[b].x, q[b].y}, {1'b1, 10'd0, 10'd0});
        check("t5_count_old", q.size() - b, 64);
        check("t5_last_old", {q[b+63].x, q[b+63].y, q[b+63].d}, {10'd31, 10'd1, 16'hBA3D});
        vs_high(3);
        check("t5_frame_cnt", frame_cnt, 5);
        gap(2);
        b = q.size();
        send_pixels(0, 32, 0, 1'b0); gap(2);
        enable = 1'b0;
        lines(1, 7, 1'b0);
        vs_high(3);
        check("t5_count_new", q.size() - b, 16);
        check("t5_new_first", {q[b].d, q[b].sof}, {16'h007E, 1'b1});
        check("t5_new_eol", {q[b+7].x, q[b+7].eol, q[b+7].d}, {10'd7, 1'b1, 16'h0062});
        check("t5_new_row1", {q[b+8].x, q[b+8].y}, {10'd0, 10'd1});
        check("t5_frame_cnt_end", frame_cnt, 6);
        b = q.size();
        gap(2);
        lines(0, 2, 1'b0);
        vs_high(3);
        check("t5_disabled_count", q.size() - b, 0);
        check("t5_disabled_frames", frame_cnt, 6);

        // 6: asynchronous reset with entries in the FIFO
        enable = 1'b1; bpp2 = 1'b0; decim = 2'd0;
        px.i_ready = 1'b0;
        clk_wait(2);
        vs_high(3); gap(2);
        send_pixels(0, 5, 0, 1'b0);
        clk_wait(4);
        check("t6_held", {px.o_valid, px.o_data}, {1'b1, 16'h007E});
        rst_x = 1'b0;
        #1;
        check("t6_rst_valid", px.o_valid, 0);
        check("t6_rst_frame", frame_cnt, 0);
        check("t6_rst_ovf", ovf_cnt, 0);
        clk_wait(2);
        rst_x = 1'b1;
        px.i_ready = 1'b1;
        b = q.size(); lb = lerr_cnt;
        send_pixels(5, 27, 0, 1'b0); gap(2);
        lines(1, 1, 1'b0);
        clk_wait(10);
        check("t6_no_pix_before_vs", q.size() - b, 0);
        vs_high(3); gap(2);
        lines(0, 1, 1'b0);
        check("t6_count", q.size() - b, 32);
        check("t6_first", {q[b].sof, q[b].x, q[b].y, q[b].d}, {1'b1, 10'd0, 10'd0, 16'h007E});
        check("t6_line_err", lerr_cnt - lb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
